// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with owner-side bus multiplexer.
//
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   mN_req_                     active-low bus request from master N (N = 0..3)
//   mN_addr, mN_as_, mN_rw      address, active-low strobe, direction (1 = read) from master N
//   mN_wr_data                  write data from master N
//   mN_grnt_                    active-low grant to master N, exactly one low at all times
//   bus_addr, bus_as_, bus_rw,
//   bus_wr_data                 owner's signals forwarded to the address decoder / bus
//   arb_timeout                 one-cycle pulse on a forced hand-over
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   defined   - a contended owner is forced off after MAX_HOLD cycles, pulsing arb_timeout
//   undefined - the owner holds indefinitely and arb_timeout is tied low
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 16
`endif
module bus_arbiter #(
    parameter int ADDR_W   = `BUS_ADDR_WIDTH,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_,
    input  logic              m1_req_,
    input  logic              m2_req_,
    input  logic              m3_req_,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [ADDR_W-1:0] m3_addr,
    input  logic              m0_as_,
    input  logic              m1_as_,
    input  logic              m2_as_,
    input  logic              m3_as_,
    input  logic              m0_rw,
    input  logic              m1_rw,
    input  logic              m2_rw,
    input  logic              m3_rw,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic [DATA_W-1:0] m2_wr_data,
    input  logic [DATA_W-1:0] m3_wr_data,
    output logic              m0_grnt_,
    output logic              m1_grnt_,
    output logic              m2_grnt_,
    output logic              m3_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    output logic              arb_timeout
);
    typedef enum logic [1:0] {OWN0, OWN1, OWN2, OWN3} owner_t;
    owner_t     owner_q, owner_d, nxt;
    logic [3:0] req;
    logic       own_req, other_req;
    assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign own_req   = req[owner_q];
    assign other_req = |(req & ~(4'b0001 << owner_q));
    // Scan farthest-first so the closest requester in round-robin order wins;
    // with no other requester nxt stays on the owner, which parks the bus.
    always_comb begin
        nxt = owner_q;
        for (int i = 3; i >= 1; i--)
            if (req[2'(owner_q) + 2'(i)]) nxt = owner_t'(2'(owner_q) + 2'(i));
    end
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic          force_ho, to_q;
    // The edge that would bring the count to MAX_HOLD is the forcing edge.
    assign force_ho    = own_req && other_req && hold_q == HW'(MAX_HOLD - 1);
    assign hold_d      = (own_req && other_req && !force_ho) ? hold_q + 1'b1 : '0;
    assign owner_d     = (!own_req || force_ho) ? nxt : owner_q;
    assign arb_timeout = to_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            owner_q <= OWN0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            to_q    <= force_ho;
        end
`else
    assign owner_d     = own_req ? owner_q : nxt;
    assign arb_timeout = 1'b0;
    always_ff @(posedge clk or posedge reset)
        if (reset) owner_q <= OWN0;
        else       owner_q <= owner_d;
`endif
    assign m0_grnt_    = owner_q != OWN0;
    assign m1_grnt_    = owner_q != OWN1;
    assign m2_grnt_    = owner_q != OWN2;
    assign m3_grnt_    = owner_q != OWN3;
    assign bus_addr    = owner_q == OWN0 ? m0_addr : owner_q == OWN1 ? m1_addr :
                         owner_q == OWN2 ? m2_addr : m3_addr;
    assign bus_as_     = owner_q == OWN0 ? m0_as_ : owner_q == OWN1 ? m1_as_ :
                         owner_q == OWN2 ? m2_as_ : m3_as_;
    assign bus_rw      = owner_q == OWN0 ? m0_rw : owner_q == OWN1 ? m1_rw :
                         owner_q == OWN2 ? m2_rw : m3_rw;
    assign bus_wr_data = owner_q == OWN0 ? m0_wr_data : owner_q == OWN1 ? m1_wr_data :
                         owner_q == OWN2 ? m2_wr_data : m3_wr_data;
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter and master-side multiplexer for the shared system bus, with four bus masters.
- Sits directly upstream of the address decoder: grants the bus to one master, then forwards that master's address, strobe, direction and write data onto the bus.
- The decoder derives the slave chip selects from the forwarded bus_addr.

Parameters:
- ADDR_W, default `BUS_ADDR_WIDTH: width of master and bus addresses.
- DATA_W, default 32: width of write data.
- MAX_HOLD, default 16: hold-cycle limit. Used only when BUS_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_req_ .. m3_req_  input  1 each  active-low bus request from master n.
- m0_addr .. m3_addr  input  ADDR_W each  address from master n.
- m0_as_ .. m3_as_  input  1 each  active-low address strobe from master n.
- m0_rw .. m3_rw  input  1 each  1 = read, 0 = write.
- m0_wr_data .. m3_wr_data  input  DATA_W each  write data from master n.
- m0_grnt_ .. m3_grnt_  output  1 each  active-low grant, exactly one low at all times.
- bus_addr  output  ADDR_W  forwarded address of owner (to address decoder).
- bus_as_  output  1  forwarded strobe of owner.
- bus_rw  output  1  forwarded direction of owner.
- bus_wr_data  output  DATA_W  forwarded write data of owner.
- arb_timeout  output  1  one-cycle pulse on forced hand-over (see Optional Feature).

Behaviour:
- State: 2-bit owner register, with states OWN0..OWN3. Grants are decoded from owner registers, so there are no combinational paths from req to grant.
- Reset (asynchronous, while reset=1):
  - owner=OWN0.
  - m0_grnt_=0; m1_grnt_, m2_grnt_, m3_grnt_ = 1.
  - arb_timeout=0.
  - Bus outputs reflect master 0 inputs.
- Hold rule: while the owner's req_ is sampled 0, owner is unchanged. There is no preemption (except under the optional feature).
- Release rule: owner's req_ sampled 1 at a rising edge:
  - Search order: owner+1, owner+2, owner+3 (mod 4). The first master with req_=0 becomes owner at that edge.
  - The new grant is visible in the same cycle the edge completes (1-cycle hand-over latency).
- If no other master requests, owner is unchanged, so the idle bus stays parked on the last owner.
- The owner's own req_ is not re-examined during the search; it re-requests only after the others are served.
- Simultaneous requests: resolved purely by round-robin distance from the current owner.
- Multiplexer: bus_addr, bus_as_, bus_rw and bus_wr_data are purely combinational selects of the owner's inputs.
  - Non-owner as_ values are ignored, so bus_as_ can only assert from the granted master.
- Wrap-around: owner=OWN3 searches 0, 1, 2.
- Reset mid-transfer: grant returns to master 0 immediately (asynchronously). Any in-flight strobe from another master is dropped from the bus.
- Grant vector is one-hot-low in every cycle, including during reset.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter of width $clog2(MAX_HOLD+1) counts consecutive cycles the owner keeps the grant while any other master has req_=0.
  - The counter clears on owner change, on no contention, and on reset.
  - When count reaches MAX_HOLD at an edge, ownership is forced to the next requester per the round-robin search, and arb_timeout pulses 1 for exactly one cycle.
- Undefined:
  - No counter; arb_timeout is tied 0.
  - The owner holds indefinitely.

Test Plan:
- Reset check: assert reset with all req_=1, then release → m0_grnt_=0, others 1; bus_addr equals m0_addr (e.g. 'h105 selects slave 1 in the decoder); arb_timeout=0.
- Release hand-over: m0 owns and m2_req_=0; m0_req_ goes to 1 at edge N → after edge N, m2_grnt_=0, m0_grnt_=1; bus_addr=m2_addr ('h2A0); bus_rw=m2_rw.
- Round-robin fairness: owner=OWN1; m0, m2 and m3 all request, then the owner releases → order granted is 2, 3, 0, each holding until its own release.
- Wrap and park: owner=OWN3 releases with only m1 requesting → owner=OWN1; then m1 releases with no requests → m1 stays granted, bus_as_ follows m1_as_=1.
- Async reset mid-transfer: owner=OWN2 with m2_as_=0; pulse reset between edges → m0_grnt_=0 immediately; bus_as_ equals m0_as_.
- Timeout (macro defined, MAX_HOLD=4): m0 holds while m1 requests → after 4 contended cycles, grant moves to m1, arb_timeout=1 for one cycle. With macro undefined, m0 keeps the grant for 100 cycles and arb_timeout stays 0.
